// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Requester side of the instruction memory port. The unit owns the fetch PC and
// presents it directly as the memory byte address. It captures each returned word,
// together with the PC it came from, into a small prefetch FIFO. Decode drains the
// FIFO over a valid/ready handshake. An execute-stage redirect flushes the FIFO and
// restarts fetch at the word-aligned target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_en,
  output logic [31:0]                     imem_addr,
  input  logic [31:0]                     imem_rdata,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_instr,
  output logic [31:0]                     out_pc,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  // Fetch PC and FIFO bookkeeping.
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // FIFO storage. Each entry holds the fetch PC and the word read from it.
  logic [31:0] pc_mem_q    [FIFO_DEPTH];
  logic [31:0] instr_mem_q [FIFO_DEPTH];

  // Handshake terms.
  logic empty_s;
  logic pop_s;
  logic push_s;

  assign empty_s = (level_q == {LVL_W{1'b0}});

  // Decode-facing outputs come straight from registered state. The head entry is
  // gated to zero when empty so no stale data ever leaks out.
  assign out_valid  = ~empty_s;
  assign out_pc     = empty_s ? 32'h0000_0000 : pc_mem_q[rd_ptr_q];
  assign out_instr  = empty_s ? 32'h0000_0000 : instr_mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign imem_addr  = fetch_pc_q;

  // Next-state logic: redirect flush has priority over push/pop bookkeeping.
  always_comb begin
    pop_s      = out_valid & out_ready;
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    push_s     = fetch_en & ~redirect_valid & ((level_q < DEPTH_L) | pop_s);
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (redirect_valid) begin
      // A coincident pop is a completed transfer; decode already owns that word,
      // so flushing everything else is all that is needed.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      level_d    = {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        // Natural 32-bit wrap: 32'hFFFF_FFFC advances to 32'h0.
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end else begin
        // Hold the address so the same word is re-read next cycle.
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage: cleared on reset so every entry is defined, written at the tail on push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0000_0000;
        instr_mem_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= pc_mem_q[i];
        instr_mem_q[i] <= instr_mem_q[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fifo_level;

  int errors;
  int checks;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fifo_level     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: three given words, a recognisable pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hFFC4_A303;
      32'h0000_0004: mem_word = 32'h0062_E3B3;
      32'h0000_0008: mem_word = 32'h0062_F433;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge, then release with the given control inputs.
  task automatic do_reset(input logic rdy, input logic en);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    step();
    rst = 1'b1;
    out_ready = rdy;
    fetch_en = en;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", out_pc); end
    checks++;
    if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=00000000", out_instr); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'h0; exp_in[0] = 32'hFFC4_A303;
    exp_pc[1] = 32'h4; exp_in[1] = 32'h0062_E3B3;
    exp_pc[2] = 32'h8; exp_in[2] = 32'h0062_F433;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
        errors++;
        $display("FAIL stream[%0d] got v=%b pc=%h in=%h exp v=1 pc=%h in=%h",
                 i, out_valid, out_pc, out_instr, exp_pc[i], exp_in[i]);
      end
      checks++;
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, fifo_level); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset(1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (fifo_level !== ((i > 4) ? 3'd4 : 3'(i))) begin
        errors++;
        $display("FAIL bp_level[%0d] got=%0d exp=%0d", i, fifo_level, (i > 4) ? 4 : i);
      end
      checks++;
      if (out_pc !== 32'h0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_head[%0d] got v=%b pc=%h exp v=1 pc=00000000", i, out_valid, out_pc);
      end
    end
    checks++;
    if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr got=%h exp=00000010", imem_addr); end
    out_ready = 1'b1;
    exp_pc = 32'h4;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL bp_drain[%0d] got v=%b pc=%h in=%h exp v=1 pc=%h in=%h",
                 i, out_valid, out_pc, out_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0, 1'b1);
    step(); step(); step();
    checks++;
    if (fifo_level !== 3'd3) begin errors++; $display("FAIL redir_pre_level got=%0d exp=3", fifo_level); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0008;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL redir_flush got v=%b lvl=%0d addr=%h exp v=0 lvl=0 addr=00000008",
               out_valid, fifo_level, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h0062_F433) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%h in=%h exp v=1 pc=00000008 in=0062f433",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_misaligned_wrap();
    out_ready = 1'b1;
    fetch_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_000B;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL misalign_addr got=%h exp=00000008", imem_addr); end
    step();
    checks++;
    if (out_pc !== 32'h8) begin errors++; $display("FAIL misalign_pc got=%h exp=00000008", out_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_addr got addr=%h v=%b exp addr=fffffffc v=0", imem_addr, out_valid);
    end
    step();
    checks++;
    if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'hA5A5_FFFC || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top got pc=%h in=%h addr=%h exp pc=fffffffc in=a5a5fffc addr=00000000",
               out_pc, out_instr, imem_addr);
    end
    step();
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'hFFC4_A303) begin
      errors++;
      $display("FAIL wrap_zero got pc=%h in=%h exp pc=00000000 in=ffc4a303", out_pc, out_instr);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_pc;
    do_reset(1'b0, 1'b1);
    step(); step(); step(); step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || imem_addr !== 32'h14 || out_pc !== 32'h4) begin
      errors++;
      $display("FAIL full_pp got lvl=%0d addr=%h pc=%h exp lvl=4 addr=00000014 pc=00000004",
               fifo_level, imem_addr, out_pc);
    end
    fetch_en = 1'b0;
    out_ready = 1'b1;
    exp_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_addr !== 32'h14 || fifo_level !== 3'(3 - i) || out_pc !== exp_pc) begin
        errors++;
        $display("FAIL stall[%0d] got addr=%h lvl=%0d pc=%h exp addr=00000014 lvl=%0d pc=%h",
                 i, imem_addr, fifo_level, out_pc, 3 - i, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    checks++;
    if (out_pc !== 32'h10 || out_instr !== mem_word(32'h10)) begin
      errors++;
      $display("FAIL tail_entry got pc=%h in=%h exp pc=00000010 in=%h", out_pc, out_instr, mem_word(32'h10));
    end
  endtask

  task automatic test_reset_dominates();
    do_reset(1'b0, 1'b1);
    step(); step(); step(); step();
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL dom_pre_level got=%0d exp=4", fifo_level); end
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    out_ready = 1'b1;
    step();
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_dom got lvl=%0d v=%b addr=%h pc=%h exp lvl=0 v=0 addr=00000000 pc=00000000",
               fifo_level, out_valid, imem_addr, out_pc);
    end
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hFFC4_A303) begin
      errors++;
      $display("FAIL rst_restart got v=%b pc=%h in=%h exp v=1 pc=00000000 in=ffc4a303",
               out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned_wrap();
    test_full_push_pop();
    test_reset_dominates();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
